// File: rtl/sc_nco_pkg.sv
// rtl/sc_nco_pkg.sv - shared widths, LUT latency and address helpers for the quadrature NCO
package sc_nco_pkg;

    localparam int PW      = 32;
    localparam int ASZ     = 10;
    localparam int DSZ     = 18;
    localparam int LUT_LAT = 2;

    // Quarter turn of the LUT; integrators tie ofs to this for sine/cosine pairs.
    localparam logic [ASZ-1:0] QTR = ASZ'(1 << (ASZ - 2));

    function automatic logic [ASZ-1:0] phase_to_addr(input logic [PW-1:0] phase);
        return phase[PW-1 -: ASZ];
    endfunction

endpackage

// File: rtl/sc_nco_phase.sv
// rtl/sc_nco_phase.sv - phase accumulator with glitch-free frequency update and hard sync
module sc_nco_phase
    import sc_nco_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_ena,
    input  logic [PW-1:0] i_freq,
    input  logic          i_freq_ld,
    input  logic          i_sync,
    output logic [PW-1:0] o_phase_nxt,
    output logic          o_wrap
);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] r_freq_act;
    logic [PW-1:0] r_freq_pend;
    logic          r_pend_flag;
    logic          r_sync_pend;
    logic          r_wrap;

    logic          w_sync_now;
    logic          w_pend_now;
    logic [PW-1:0] w_pend_val;
    logic [PW:0]   w_sum;

    // A load or sync arriving on the ena cycle itself takes effect at that same edge.
    assign w_sync_now  = i_sync | r_sync_pend;
    assign w_pend_now  = i_freq_ld | r_pend_flag;
    assign w_pend_val  = i_freq_ld ? i_freq : r_freq_pend;
    assign w_sum       = {1'b0, r_phase} + {1'b0, r_freq_act};
    assign o_phase_nxt = w_sync_now ? '0 : w_sum[PW-1:0];
    assign o_wrap      = r_wrap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase     <= '0;
            r_freq_act  <= '0;
            r_freq_pend <= '0;
            r_pend_flag <= 1'b0;
            r_sync_pend <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_freq_ld) begin
                r_freq_pend <= i_freq;
                r_pend_flag <= 1'b1;
            end
            if (i_sync) begin
                r_sync_pend <= 1'b1;
            end
            if (i_ena) begin
                // This step still uses the old increment; the new one applies from the next ena.
                r_phase     <= o_phase_nxt;
                r_wrap      <= ~w_sync_now & w_sum[PW];
                r_sync_pend <= 1'b0;
                if (w_pend_now) begin
                    r_freq_act  <= w_pend_val;
                    r_pend_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sc_nco.sv
// rtl/sc_nco.sv - quadrature NCO driving two LUT addresses and capturing aligned samples
module sc_nco
    import sc_nco_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic [PW-1:0]         freq,
    input  logic                  freq_ld,
    input  logic [ASZ-1:0]        ofs,
    input  logic                  sync,
    output logic [ASZ-1:0]        lut_a0,
    output logic [ASZ-1:0]        lut_a1,
    input  logic signed [DSZ-1:0] lut_d0,
    input  logic signed [DSZ-1:0] lut_d1,
    output logic signed [DSZ-1:0] out0,
    output logic signed [DSZ-1:0] out1,
    output logic                  out_valid,
    output logic                  wrap
);

    logic [PW-1:0]         w_phase_nxt;
    logic [ASZ-1:0]        w_addr;
    logic [ASZ-1:0]        r_lut_a0;
    logic [ASZ-1:0]        r_lut_a1;
    logic [LUT_LAT:0]      r_vpipe;
    logic signed [DSZ-1:0] r_out0;
    logic signed [DSZ-1:0] r_out1;
    logic                  r_out_valid;

    sc_nco_phase u_phase (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ena       (ena),
        .i_freq      (freq),
        .i_freq_ld   (freq_ld),
        .i_sync      (sync),
        .o_phase_nxt (w_phase_nxt),
        .o_wrap      (wrap)
    );

    // Addresses are taken from the post-step phase so they line up with the wrap pulse.
    assign w_addr = phase_to_addr(w_phase_nxt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lut_a0    <= '0;
            r_lut_a1    <= ofs;
            r_vpipe     <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (ena) begin
                r_lut_a0 <= w_addr;
                r_lut_a1 <= w_addr + ofs;
            end
            r_vpipe     <= {r_vpipe[LUT_LAT-1:0], ena};
            r_out_valid <= r_vpipe[LUT_LAT];
            if (r_vpipe[LUT_LAT]) begin
                r_out0 <= lut_d0;
                r_out1 <= lut_d1;
            end
        end
    end

    assign lut_a0    = r_lut_a0;
    assign lut_a1    = r_lut_a1;
    assign out0      = r_out0;
    assign out1      = r_out1;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sc_nco.sv
// tb/tb_sc_nco.sv - randomized and directed bench for sc_nco against a behavioural model
module tb_sc_nco;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ena;
    logic [31:0]        freq;
    logic               freq_ld;
    logic [9:0]         ofs;
    logic               sync;
    logic [9:0]         lut_a0;
    logic [9:0]         lut_a1;
    logic signed [17:0] lut_d0 = '0;
    logic signed [17:0] lut_d1 = '0;
    logic signed [17:0] out0;
    logic signed [17:0] out1;
    logic               out_valid;
    logic               wrap;

    always #5 clk = ~clk;

    sc_nco dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ena       (ena),
        .freq      (freq),
        .freq_ld   (freq_ld),
        .ofs       (ofs),
        .sync      (sync),
        .lut_a0    (lut_a0),
        .lut_a1    (lut_a1),
        .lut_d0    (lut_d0),
        .lut_d1    (lut_d1),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    function automatic logic signed [17:0] lut_f(input logic [9:0] a);
        return {a, a[7:0]} ^ 18'h2A5A5;
    endfunction

    // Two-register LUT: address register then BRAM output register.
    logic [9:0] r1a0 = '0;
    logic [9:0] r1a1 = '0;
    always @(posedge clk) begin
        r1a0   <= lut_a0;
        r1a1   <= lut_a1;
        lut_d0 <= lut_f(r1a0);
        lut_d1 <= lut_f(r1a1);
    end

    typedef struct {
        int       due;
        logic [9:0] a0;
        logic [9:0] a1;
    } smp_t;

    smp_t               q[$];
    logic [31:0]        m_phase, m_act, m_pend;
    logic               m_pflag, m_spend, m_wrap, m_ov;
    logic [9:0]         m_a0, m_a1;
    logic signed [17:0] m_o0, m_o1;
    logic [32:0]        m_sum;
    int                 cyc = 0;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 n_wrap;
    int                 n_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic ld, input logic s,
                        input logic [31:0] f, input logic rn, input logic [9:0] o);
        ena = e; freq_ld = ld; sync = s; freq = f; reset_n = rn; ofs = o;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            m_phase = '0; m_act = '0; m_pend = '0; m_pflag = 1'b0; m_spend = 1'b0;
            m_a0 = '0; m_a1 = o; m_wrap = 1'b0; m_ov = 1'b0; m_o0 = '0; m_o1 = '0;
            q.delete();
        end else begin
            m_ov   = 1'b0;
            m_wrap = 1'b0;
            if (ld) begin
                m_pend  = f;
                m_pflag = 1'b1;
            end
            if (s) m_spend = 1'b1;
            if (e) begin
                if (m_spend) begin
                    m_phase = '0;
                    m_spend = 1'b0;
                end else begin
                    m_sum   = {1'b0, m_phase} + {1'b0, m_act};
                    m_phase = m_sum[31:0];
                    m_wrap  = m_sum[32];
                end
                if (m_pflag) begin
                    m_act   = m_pend;
                    m_pflag = 1'b0;
                end
                m_a0 = m_phase[31:22];
                m_a1 = m_a0 + o;
                q.push_back('{cyc + 3, m_a0, m_a1});
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                m_ov = 1'b1;
                m_o0 = lut_f(q[0].a0);
                m_o1 = lut_f(q[0].a1);
                void'(q.pop_front());
            end
        end
        #1;
        chk("lut_a0", 32'(lut_a0), 32'(m_a0));
        chk("lut_a1", 32'(lut_a1), 32'(m_a1));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out0", 32'(out0), 32'(m_o0));
        chk("out1", 32'(out1), 32'(m_o1));
    endtask

    initial begin
        ena = 1'b0; freq_ld = 1'b0; sync = 1'b0; freq = '0; reset_n = 1'b0; ofs = 10'd256;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'd0, 0, 10'd256);
        chk("rst_a0", 32'(lut_a0), 32'd0);
        chk("rst_a1", 32'(lut_a1), 32'd256);
        chk("rst_valid", 32'(out_valid), 32'd0);

        step(1, 1, 1, 32'h0040_0000, 1, 10'd256);
        chk("sync_ld_a0", 32'(lut_a0), 32'd0);
        n_wrap = 0;
        for (int i = 0; i < 2048; i++) begin
            step(1, 0, 0, 32'd0, 1, 10'd256);
            if (i == 0) chk("first_step_a0", 32'(lut_a0), 32'd1);
            if (wrap === 1'b1) n_wrap++;
        end
        chk("wrap_count", 32'(n_wrap), 32'd2);
        chk("full_turn_a0", 32'(lut_a0), 32'd0);

        step(1, 1, 0, 32'h0080_0000, 1, 10'd256);
        chk("ld_edge_a0", 32'(lut_a0), 32'd1);
        step(1, 0, 0, 32'd0, 1, 10'd256);
        chk("new_inc_a0", 32'(lut_a0), 32'd3);
        step(1, 0, 0, 32'd0, 1, 10'd256);
        chk("new_inc2_a0", 32'(lut_a0), 32'd5);

        step(0, 0, 1, 32'd0, 1, 10'd256);
        step(0, 0, 0, 32'd0, 1, 10'd256);
        step(1, 0, 0, 32'd0, 1, 10'd256);
        chk("sync_a0", 32'(lut_a0), 32'd0);
        chk("sync_wrap", 32'(wrap), 32'd0);
        step(1, 0, 0, 32'd0, 1, 10'd256);
        chk("post_sync_a0", 32'(lut_a0), 32'd2);

        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'd0, 1, 10'd256);
        step(1, 0, 0, 32'd0, 1, 10'd256);
        n_ov = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 32'd0, 1, 10'd256);
            if (out_valid === 1'b1) begin
                n_ov++;
                chk("single_lat", 32'(i), 32'd2);
            end
        end
        chk("single_count", 32'(n_ov), 32'd1);

        step(1, 1, 1, 32'd100 << 22, 1, 10'd1000);
        step(1, 0, 0, 32'd0, 1, 10'd1000);
        chk("ofs_a0", 32'(lut_a0), 32'd100);
        chk("ofs_a1", 32'(lut_a1), 32'd76);

        step(1, 0, 0, 32'd0, 1, 10'd1000);
        step(1, 0, 0, 32'd0, 1, 10'd1000);
        step(0, 0, 0, 32'd0, 0, 10'd1000);
        step(0, 0, 0, 32'd0, 0, 10'd1000);
        n_ov = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 32'd0, 1, 10'd1000);
            if (out_valid === 1'b1) n_ov++;
        end
        chk("flush_count", 32'(n_ov), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) == 0, ($urandom % 25) == 0,
                 $urandom, ($urandom % 300) != 0,
                 (($urandom % 50) == 0) ? 10'($urandom) : ofs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
